// File: rtl/reg_file.sv
// Register file for the arbitrary function generator: control, shadow
// parameters with boundary-synchronous apply, and waveform RAM streaming.
module reg_file #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_AW     = 10
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  rf_re_i,
    input  logic                  rf_we_i,
    input  logic [ADDR_WIDTH-1:0] rf_addr_i,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    output logic [DATA_WIDTH-1:0] rf_data_o,
    input  logic                  gen_sync_i,
    input  logic                  gen_running_i,
    output logic                  gen_en_o,
    output logic                  gen_mode_o,
    output logic [31:0]           gen_freq_o,
    output logic [7:0]            gen_amp_o,
    output logic [7:0]            gen_offset_o,
    output logic                  mem_we_o,
    output logic [MEM_AW-1:0]     mem_addr_o,
    output logic [7:0]            mem_data_o
);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(8'h01);
    localparam logic [ADDR_WIDTH-1:0] A_FREQ0  = ADDR_WIDTH'(8'h02);
    localparam logic [ADDR_WIDTH-1:0] A_FREQ1  = ADDR_WIDTH'(8'h03);
    localparam logic [ADDR_WIDTH-1:0] A_FREQ2  = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] A_FREQ3  = ADDR_WIDTH'(8'h05);
    localparam logic [ADDR_WIDTH-1:0] A_AMP    = ADDR_WIDTH'(8'h06);
    localparam logic [ADDR_WIDTH-1:0] A_OFFSET = ADDR_WIDTH'(8'h07);
    localparam logic [ADDR_WIDTH-1:0] A_PTR_L  = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] A_PTR_H  = ADDR_WIDTH'(8'h09);
    localparam logic [ADDR_WIDTH-1:0] A_MEM    = ADDR_WIDTH'(8'h0A);
    localparam logic [ADDR_WIDTH-1:0] A_ID     = ADDR_WIDTH'(8'h0B);
    localparam logic [7:0]            ID_VAL   = 8'hA5;

    logic [7:0]        wr_byte;
    logic [7:0]        rd_byte;

    logic              sel_ctrl;
    logic              sel_status;
    logic              sel_f0;
    logic              sel_f1;
    logic              sel_f2;
    logic              sel_f3;
    logic              sel_amp;
    logic              sel_off;
    logic              sel_ptr_l;
    logic              sel_ptr_h;
    logic              sel_mem;
    logic              sel_id;

    logic              we_ctrl;
    logic              we_mem;
    logic              we_ptr_l;
    logic              we_ptr_h;

    logic              en_q;
    logic              mode_q;
    logic              pend_q;
    logic              ovf_q;
    logic [31:0]       freq_q;
    logic [7:0]        amp_q;
    logic [7:0]        off_q;
    logic [MEM_AW-1:0] ptr_q;

    logic [31:0]       freq_d;
    logic [7:0]        amp_d;
    logic [7:0]        off_d;

    logic              apply_wr;
    logic              xfer;
    logic              ovf_set;
    logic              status_rd;

    assign wr_byte    = rf_data_i[7:0];

    assign sel_ctrl   = (rf_addr_i == A_CTRL);
    assign sel_status = (rf_addr_i == A_STATUS);
    assign sel_f0     = (rf_addr_i == A_FREQ0);
    assign sel_f1     = (rf_addr_i == A_FREQ1);
    assign sel_f2     = (rf_addr_i == A_FREQ2);
    assign sel_f3     = (rf_addr_i == A_FREQ3);
    assign sel_amp    = (rf_addr_i == A_AMP);
    assign sel_off    = (rf_addr_i == A_OFFSET);
    assign sel_ptr_l  = (rf_addr_i == A_PTR_L);
    assign sel_ptr_h  = (rf_addr_i == A_PTR_H);
    assign sel_mem    = (rf_addr_i == A_MEM);
    assign sel_id     = (rf_addr_i == A_ID);

    assign we_ctrl    = rf_we_i & sel_ctrl;
    assign we_mem     = rf_we_i & sel_mem;
    assign we_ptr_l   = rf_we_i & sel_ptr_l;
    assign we_ptr_h   = rf_we_i & sel_ptr_h;

    assign apply_wr   = we_ctrl & wr_byte[2];
    // EN here is the value before any same-cycle CTRL write.
    assign xfer       = pend_q & (gen_sync_i | ~en_q);
    assign ovf_set    = we_mem & (&ptr_q);
    assign status_rd  = rf_re_i & sel_status;

    assign gen_en_o   = en_q;
    assign gen_mode_o = mode_q;

    // Shadow values as they will be after this edge; the apply copies these.
    always_comb begin
        freq_d = freq_q;
        amp_d  = amp_q;
        off_d  = off_q;
        if (rf_we_i) begin
            if (sel_f0)  freq_d[7:0]   = wr_byte;
            if (sel_f1)  freq_d[15:8]  = wr_byte;
            if (sel_f2)  freq_d[23:16] = wr_byte;
            if (sel_f3)  freq_d[31:24] = wr_byte;
            if (sel_amp) amp_d         = wr_byte;
            if (sel_off) off_d         = wr_byte;
        end
    end

    always_comb begin
        rd_byte = '0;
        if (rf_re_i) begin
            unique case (1'b1)
                sel_ctrl:   rd_byte = {6'd0, mode_q, en_q};
                sel_status: rd_byte = {5'd0, ovf_q, pend_q, gen_running_i};
                sel_f0:     rd_byte = freq_q[7:0];
                sel_f1:     rd_byte = freq_q[15:8];
                sel_f2:     rd_byte = freq_q[23:16];
                sel_f3:     rd_byte = freq_q[31:24];
                sel_amp:    rd_byte = amp_q;
                sel_off:    rd_byte = off_q;
                sel_ptr_l:  rd_byte = ptr_q[7:0];
                sel_ptr_h:  rd_byte = 8'(ptr_q[MEM_AW-1:8]);
                sel_id:     rd_byte = ID_VAL;
                default:    rd_byte = '0;
            endcase
        end
    end

    assign rf_data_o = DATA_WIDTH'(rd_byte);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            en_q   <= 1'b0;
            mode_q <= 1'b0;
            freq_q <= '0;
            amp_q  <= '0;
            off_q  <= '0;
        end else begin
            if (we_ctrl) begin
                en_q   <= wr_byte[0];
                mode_q <= wr_byte[1];
            end
            freq_q <= freq_d;
            amp_q  <= amp_d;
            off_q  <= off_d;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            pend_q       <= 1'b0;
            gen_freq_o   <= '0;
            gen_amp_o    <= '0;
            gen_offset_o <= '0;
        end else begin
            // A fresh APPLY re-arms even when a transfer happens now.
            pend_q <= apply_wr | (pend_q & ~xfer);
            if (xfer) begin
                gen_freq_o   <= freq_d;
                gen_amp_o    <= amp_d;
                gen_offset_o <= off_d;
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ovf_q      <= 1'b0;
            ptr_q      <= '0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            ovf_q    <= ovf_set | (ovf_q & ~status_rd);
            mem_we_o <= we_mem;
            if (we_mem) begin
                mem_addr_o <= ptr_q;
                mem_data_o <= wr_byte;
                ptr_q      <= ptr_q + MEM_AW'(1);
            end else if (we_ptr_l) begin
                ptr_q[7:0] <= wr_byte;
            end else if (we_ptr_h) begin
                ptr_q[MEM_AW-1:8] <= wr_byte[MEM_AW-9:0];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed scenarios plus randomized traffic
// compared against a register-map level reference model.
module tb_reg_file;

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_i = 1'b0;
    logic        rf_re_i = 1'b0;
    logic        rf_we_i = 1'b0;
    logic [6:0]  rf_addr_i = '0;
    logic [7:0]  rf_data_i = '0;
    logic [7:0]  rf_data_o;
    logic        gen_sync_i = 1'b0;
    logic        gen_running_i = 1'b0;
    logic        gen_en_o;
    logic        gen_mode_o;
    logic [31:0] gen_freq_o;
    logic [7:0]  gen_amp_o;
    logic [7:0]  gen_offset_o;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [7:0]  mem_data_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit        m_en, m_mode, m_pend, m_ovf;
    bit [31:0] m_freq, a_freq;
    bit [7:0]  m_amp, m_off, a_amp, a_off;
    int        m_ptr;
    bit        e_mem_we;
    int        e_mem_addr;
    bit [7:0]  e_mem_data;

    reg_file dut (
        .sys_clk_i    (sys_clk_i),
        .sys_rst_i    (sys_rst_i),
        .rf_re_i      (rf_re_i),
        .rf_we_i      (rf_we_i),
        .rf_addr_i    (rf_addr_i),
        .rf_data_i    (rf_data_i),
        .rf_data_o    (rf_data_o),
        .gen_sync_i   (gen_sync_i),
        .gen_running_i(gen_running_i),
        .gen_en_o     (gen_en_o),
        .gen_mode_o   (gen_mode_o),
        .gen_freq_o   (gen_freq_o),
        .gen_amp_o    (gen_amp_o),
        .gen_offset_o (gen_offset_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    task automatic model_reset();
        m_en = 0; m_mode = 0; m_pend = 0; m_ovf = 0;
        m_freq = 0; m_amp = 0; m_off = 0;
        a_freq = 0; a_amp = 0; a_off = 0;
        m_ptr = 0;
        e_mem_we = 0; e_mem_addr = 0; e_mem_data = 0;
    endtask

    function automatic logic [7:0] m_read(input int addr);
        case (addr)
            0:       return {6'd0, m_mode, m_en};
            1:       return {5'd0, m_ovf, m_pend, gen_running_i};
            2:       return m_freq[7:0];
            3:       return m_freq[15:8];
            4:       return m_freq[23:16];
            5:       return m_freq[31:24];
            6:       return m_amp;
            7:       return m_off;
            8:       return 8'(m_ptr % 256);
            9:       return 8'(m_ptr / 256);
            11:      return 8'hA5;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_edge(input bit re, input bit we, input int addr,
                              input bit [7:0] d, input bit sync);
        bit xfer;
        bit wrap;
        xfer = m_pend && (sync || !m_en);
        wrap = we && addr == 10 && m_ptr == 1023;
        e_mem_we = we && addr == 10;
        if (we) begin
            case (addr)
                0: begin m_en = d[0]; m_mode = d[1]; end
                2, 3, 4, 5: m_freq[8*(addr-2) +: 8] = d;
                6: m_amp = d;
                7: m_off = d;
                8: m_ptr = (m_ptr / 256) * 256 + int'(d);
                9: m_ptr = (int'(d) % 4) * 256 + (m_ptr % 256);
                10: begin
                    e_mem_addr = m_ptr;
                    e_mem_data = d;
                    m_ptr = (m_ptr + 1) % 1024;
                end
                default: ;
            endcase
        end
        if (xfer) begin
            a_freq = m_freq; a_amp = m_amp; a_off = m_off;
        end
        if (we && addr == 0 && d[2]) m_pend = 1;
        else if (xfer) m_pend = 0;
        if (wrap) m_ovf = 1;
        else if (re && addr == 1) m_ovf = 0;
    endtask

    // one bus cycle; called and returns at posedge+1
    task automatic step(input bit re, input bit we, input int addr,
                        input bit [7:0] d, input bit sync,
                        output logic [7:0] rd);
        rf_re_i = re; rf_we_i = we; rf_addr_i = 7'(addr);
        rf_data_i = d; gen_sync_i = sync;
        @(negedge sys_clk_i);
        rd = rf_data_o;
        @(posedge sys_clk_i); #1;
        model_edge(re, we, addr, d, sync);
        rf_re_i = 0; rf_we_i = 0; rf_addr_i = 0; rf_data_i = 0; gen_sync_i = 0;
    endtask

    task automatic wr(input int addr, input bit [7:0] d);
        logic [7:0] unused_rd;
        step(0, 1, addr, d, 0, unused_rd);
    endtask

    task automatic rd_reg(input int addr, output logic [7:0] v);
        step(1, 0, addr, 8'h00, 0, v);
    endtask

    task automatic idle(input int n);
        logic [7:0] unused_rd;
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0, unused_rd);
    endtask

    task automatic do_reset();
        sys_rst_i = 1;
        @(posedge sys_clk_i); #1;
        sys_rst_i = 0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        gen_running_i = 0;
        do_reset();
        checks++;
        if ({gen_en_o, gen_mode_o, gen_freq_o, gen_amp_o, gen_offset_o} !== 50'd0) begin
            errors++;
            $display("FAIL rst_gen: got %h want 0",
                     {gen_en_o, gen_mode_o, gen_freq_o, gen_amp_o, gen_offset_o});
        end
        checks++;
        if ({mem_we_o, mem_addr_o, mem_data_o} !== 19'd0) begin
            errors++;
            $display("FAIL rst_mem: got %h want 0", {mem_we_o, mem_addr_o, mem_data_o});
        end
        rd_reg(11, v);
        checks++;
        if (v !== 8'hA5) begin
            errors++;
            $display("FAIL rst_id: got %h want a5", v);
        end
        for (int a = 0; a <= 10; a++) begin
            rd_reg(a, v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL rst_read_%0h: got %h want 00", a, v);
            end
        end
    endtask

    task automatic test_shadow_apply();
        logic [7:0] v;
        wr(0, 8'h01);
        wr(2, 8'h78); wr(3, 8'h56); wr(4, 8'h34); wr(5, 8'h12);
        wr(6, 8'h80); wr(7, 8'h10);
        wr(0, 8'h05);
        checks++;
        if (gen_en_o !== 1'b1) begin
            errors++;
            $display("FAIL apply_en: got %b want 1", gen_en_o);
        end
        rd_reg(1, v);
        checks++;
        if (v !== 8'h02) begin
            errors++;
            $display("FAIL apply_pending: got %h want 02", v);
        end
        idle(3);
        checks++;
        if (gen_freq_o !== 32'h0 || gen_amp_o !== 8'h0) begin
            errors++;
            $display("FAIL apply_early: got %h/%h want 0/0", gen_freq_o, gen_amp_o);
        end
        step(0, 0, 0, 8'h00, 1, v);
        checks++;
        if ({gen_freq_o, gen_amp_o, gen_offset_o} !== {32'h12345678, 8'h80, 8'h10}) begin
            errors++;
            $display("FAIL apply_xfer: got %h %h %h want 12345678 80 10",
                     gen_freq_o, gen_amp_o, gen_offset_o);
        end
        rd_reg(1, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL apply_clear: got %h want 00", v);
        end
        rd_reg(5, v);
        checks++;
        if (v !== 8'h12) begin
            errors++;
            $display("FAIL shadow_freq3: got %h want 12", v);
        end
    endtask

    task automatic test_apply_disabled();
        wr(0, 8'h00);
        wr(6, 8'h3C);
        wr(0, 8'h04);
        checks++;
        if (gen_amp_o !== 8'h80 || gen_en_o !== 1'b0) begin
            errors++;
            $display("FAIL dis_before: got amp %h en %b want 80 0", gen_amp_o, gen_en_o);
        end
        idle(1);
        checks++;
        if ({gen_freq_o, gen_amp_o, gen_offset_o} !== {32'h12345678, 8'h3C, 8'h10}) begin
            errors++;
            $display("FAIL dis_xfer: got %h %h %h want 12345678 3c 10",
                     gen_freq_o, gen_amp_o, gen_offset_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        logic [9:0] exp_a [3];
        logic [7:0] exp_d [3];
        exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000;
        exp_d[0] = 8'h11;   exp_d[1] = 8'h22;   exp_d[2] = 8'h33;
        wr(9, 8'h03);
        wr(8, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            wr(10, exp_d[i]);
            checks++;
            if ({mem_we_o, mem_addr_o, mem_data_o} !== {1'b1, exp_a[i], exp_d[i]}) begin
                errors++;
                $display("FAIL b2b_%0d: got we %b a %h d %h want 1 %h %h",
                         i, mem_we_o, mem_addr_o, mem_data_o, exp_a[i], exp_d[i]);
            end
        end
        idle(1);
        checks++;
        if ({mem_we_o, mem_addr_o, mem_data_o} !== {1'b0, 10'h000, 8'h33}) begin
            errors++;
            $display("FAIL b2b_hold: got we %b a %h d %h want 0 000 33",
                     mem_we_o, mem_addr_o, mem_data_o);
        end
        rd_reg(1, v);
        checks++;
        if (v !== 8'h04) begin
            errors++;
            $display("FAIL ovf_set: got %h want 04", v);
        end
        rd_reg(1, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL ovf_clear: got %h want 00", v);
        end
        rd_reg(8, v);
        checks++;
        if (v !== 8'h01) begin
            errors++;
            $display("FAIL ptr_l: got %h want 01", v);
        end
    endtask

    task automatic test_overflow_race();
        logic [7:0] v;
        wr(9, 8'h03);
        wr(8, 8'hFF);
        step(1, 1, 10, 8'h5A, 0, v);
        checks++;
        if (v !== 8'h00 || mem_addr_o !== 10'h3FF || mem_we_o !== 1'b1) begin
            errors++;
            $display("FAIL race_rw: got rd %h a %h we %b want 00 3ff 1",
                     v, mem_addr_o, mem_we_o);
        end
        wr(8, 8'h40);
        checks++;
        if (mem_addr_o !== 10'h3FF || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL race_ptrwr: got a %h we %b want 3ff 0", mem_addr_o, mem_we_o);
        end
        rd_reg(1, v);
        checks++;
        if (v !== 8'h04) begin
            errors++;
            $display("FAIL race_ovf: got %h want 04", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        wr(0, 8'h01);
        wr(2, 8'hAA);
        wr(0, 8'h05);
        rd_reg(1, v);
        checks++;
        if (v !== 8'h02) begin
            errors++;
            $display("FAIL mid_pending: got %h want 02", v);
        end
        rf_we_i = 1; rf_addr_i = 7'h0A; rf_data_i = 8'h99;
        do_reset();
        rf_we_i = 0; rf_addr_i = 0; rf_data_i = 0;
        checks++;
        if (mem_we_o !== 1'b0 || gen_en_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_drop: got we %b en %b want 0 0", mem_we_o, gen_en_o);
        end
        idle(1);
        checks++;
        if (mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_nopulse: got %b want 0", mem_we_o);
        end
        rd_reg(1, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL mid_status: got %h want 00", v);
        end
        step(0, 0, 0, 8'h00, 1, v);
        idle(1);
        checks++;
        if (gen_freq_o !== 32'h0) begin
            errors++;
            $display("FAIL mid_freq: got %h want 0", gen_freq_o);
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [7:0] exp;
        bit re, we, sync;
        int addr, r;
        bit [7:0] d;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            re = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            sync = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 19);
            addr = (r >= 16) ? 10 : r;
            d = 8'($urandom);
            if (addr == 9 && $urandom_range(0, 1) == 1) d = 8'h03;
            if (addr == 8 && $urandom_range(0, 1) == 1) d = 8'hF0 | 8'($urandom_range(0, 15));
            gen_running_i = 1'($urandom_range(0, 1));
            exp = re ? m_read(addr) : 8'h00;
            step(re, we, addr, d, sync, v);
            checks++;
            if (v !== exp) begin
                errors++;
                $display("FAIL rnd_rd[%0d] a=%0h: got %h want %h", n, addr, v, exp);
            end
            checks++;
            if ({gen_en_o, gen_mode_o, gen_freq_o, gen_amp_o, gen_offset_o}
                !== {m_en, m_mode, a_freq, a_amp, a_off}) begin
                errors++;
                $display("FAIL rnd_gen[%0d]: got %b%b %h %h %h want %b%b %h %h %h", n,
                         gen_en_o, gen_mode_o, gen_freq_o, gen_amp_o, gen_offset_o,
                         m_en, m_mode, a_freq, a_amp, a_off);
            end
            checks++;
            if ({mem_we_o, mem_addr_o, mem_data_o} !== {e_mem_we, 10'(e_mem_addr), e_mem_data}) begin
                errors++;
                $display("FAIL rnd_mem[%0d]: got %b %h %h want %b %h %h", n,
                         mem_we_o, mem_addr_o, mem_data_o,
                         e_mem_we, 10'(e_mem_addr), e_mem_data);
            end
        end
        gen_running_i = 0;
    endtask

    initial begin
        model_reset();
        @(posedge sys_clk_i); #1;
        test_reset();
        test_shadow_apply();
        test_apply_disabled();
        test_back_to_back();
        test_overflow_race();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
